shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter that shares one W-bit register, built from rising-edge D flip-flops with asynchronous active-low clear, between N requesters. It decides which requester may write the register each cycle and supports short locked bursts with a bounded hold time. It sits between several producer blocks and a single shared configuration/data register in the flip-flop library.

## Interface
- N, 4: number of requesters, 2..8.
- W, 8: data width of the shared register.
- MAX_HOLD, 4: maximum consecutive writes per grant, ≥1.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req  input  N  per-requester write request.
- lock  input  N  per-requester "keep ownership after this write".
- wdata  input  N*W  write data; slice i is bits [i*W +: W].
- gnt  output  N  registered one-hot grant (all zero when idle).
- owner  output  3  index of current or last owner.
- busy  output  1  high while in OWN state.
- q  output  W  shared register contents.

## Operation
- Reset value of every output and internal state:
  - q = 0, gnt = 0, owner = 0, busy = 0.
  - Round-robin pointer ptr = 0, hold count hcnt = 0, state IDLE.
  - Reset acts immediately, mid-burst included.
- IDLE state:
  - If req == 0: nothing changes, q holds.
  - Else choose the first i with req[i] = 1, scanning ptr, ptr+1, … mod N.
  - At the edge: gnt <= onehot(i), owner <= i, hcnt <= 0, state OWN.
- OWN state, owner k:
  - If req[k] = 1 at the edge: q <= wdata[k], hcnt <= hcnt+1.
  - Release when any of: req[k] = 0 (no write that cycle), lock[k] = 0, or hcnt == MAX_HOLD-1 with a write occurring.
  - On release: gnt <= 0, state IDLE, ptr <= (k+1) mod N, owner keeps k.
  - Otherwise stay in OWN with gnt unchanged.
- Only the owner can write. Requests from others are ignored while busy and stay pending.
- Requests are level-sensitive and are not latched. A request dropped before it is granted is lost.
- q changes only on an owner write or on reset.
- Widths: hcnt is clog2(MAX_HOLD)+1 bits. ptr and owner are zero-extended to 3 bits.

## Timing
- Edge E0 (IDLE, req seen): gnt is valid after E0.
- Edge E1: first write; q shows wdata[k] after E1.
- Latency from request to q update: 2 edges.
- Unlocked grant:
  - gnt is high for exactly 1 cycle and performs 1 write.
  - At least 1 idle cycle follows before the next grant, so peak throughput is 1 write per 2 cycles.
- Locked burst:
  - Writes on E1..E_MAX_HOLD (up to MAX_HOLD consecutive writes).
  - Forced release on the last write, then IDLE for 1 cycle.
- Simultaneous requests:
  - Order is strictly round-robin from ptr.
  - Each waiting requester is granted within N grants.
- Requester deasserts req while granted: no write on that edge, release on that edge.
- Reset asserted mid-burst: everything clears to reset values. After reset releases, arbitration restarts at requester 0.
- req/lock/wdata are sampled only at rising clk edges and have no combinational path to outputs.

## Test plan
- Reset:
  - Stimulus: assert rst=0 while q=0xA5 and gnt=0100.
  - Response: q=0, gnt=0, busy=0, owner=0 immediately, without waiting for a clock.
- Single unlocked write:
  - Stimulus: req=0001, wdata[0]=0x3C, lock=0.
  - Response: gnt=0001 for 1 cycle; q=0x3C after the 2nd edge; busy drops after it.
- Round-robin fairness:
  - Stimulus: req=1111 held, lock=0, wdata[i]=0x10+i.
  - Response: grant order 0,1,2,3,0; q sequence 0x10,0x11,0x12,0x13 at 2-cycle spacing.
- Locked burst with hold limit:
  - Stimulus: req=0010, lock=0010 held, wdata[1] incrementing 1,2,3,4,5.
  - Response: exactly 4 writes (q=1..4); gnt drops; the next grant to requester 1 comes 1 cycle later after re-arbitration.
- Early release and pending requests:
  - Stimulus: requester 2 locked; requester 0 also requesting; req[2] drops after 2 writes.
  - Response: no write on the drop edge; ptr=3; requester 0 is granted next (wrap-around).
- Reset mid-burst:
  - Stimulus: rst pulsed low during a locked burst by requester 3.
  - Response: all state cleared; with req=1001 after reset, requester 0 is granted first.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Purpose: round-robin arbiter that gives N requesters turns writing one shared W-bit register, with short locked bursts.
// Latency: grant is registered one edge after a request is seen; the first write lands in q on the following edge.
// Backpressure: requests from non-owners are ignored while busy and must be held to be served; a burst ends after at most MAX_HOLD writes.
module shared_reg_arbiter #(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   lock,
   input  logic [N*W-1:0] wdata,
   output logic [N-1:0]   gnt,
   output logic [2:0]     owner,
   output logic           busy,
   output logic [W-1:0]   q
);

   localparam int HW = $clog2(MAX_HOLD) + 1;

   typedef enum logic {IDLE, OWN} state_t;

   state_t        state;
   logic [2:0]    ptr;
   logic [HW-1:0] hcnt;

   logic [2:0]    pick;
   logic          pick_vld;
   logic [N-1:0]  pick_oh;
   logic          own_req;
   logic          own_lock;
   logic [W-1:0]  own_data;
   logic          last_write;
   logic          rel_own;
   logic [2:0]    ptr_next;

   // Pick the requester closest to ptr going upward with wrap-around.
   always_comb begin
      int best_d;
      int d;
      pick     = '0;
      pick_vld = 1'b0;
      best_d   = N;
      d        = 0;
      for (int i = 0; i < N; i++) begin
         d = i - int'(ptr);
         if (d < 0) d = d + N;
         if (req[i] && (d < best_d)) begin
            best_d   = d;
            pick     = 3'(i);
            pick_vld = 1'b1;
         end
      end
   end

   // One-hot form of the picked requester, loaded into gnt on a new grant.
   always_comb begin
      pick_oh = '0;
      for (int i = 0; i < N; i++) begin
         pick_oh[i] = (pick == 3'(i));
      end
   end

   // Select the current owner's request, lock and data slice.
   always_comb begin
      own_req  = 1'b0;
      own_lock = 1'b0;
      own_data = '0;
      for (int i = 0; i < N; i++) begin
         if (owner == 3'(i)) begin
            own_req  = req[i];
            own_lock = lock[i];
            own_data = wdata[i*W +: W];
         end
      end
   end

   // Release on a dropped request, an unlocked write, or the final write allowed by the hold limit.
   always_comb begin
      last_write = own_req && (hcnt == HW'(MAX_HOLD - 1));
      rel_own    = !own_req || !own_lock || last_write;
      ptr_next   = (owner == 3'(N - 1)) ? 3'd0 : owner + 3'd1;
   end

   // Arbitration FSM with registered grant/owner/busy and the shared register itself.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ptr   <= '0;
         hcnt  <= '0;
         gnt   <= '0;
         owner <= '0;
         busy  <= 1'b0;
         q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  gnt   <= pick_oh;
                  owner <= pick;
                  hcnt  <= '0;
                  busy  <= 1'b1;
                  state <= OWN;
               end
            end
            OWN: begin
               if (own_req) begin
                  q    <= own_data;
                  hcnt <= hcnt + HW'(1);
               end
               if (rel_own) begin
                  gnt   <= '0;
                  busy  <= 1'b0;
                  ptr   <= ptr_next;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios with literal expectations plus a per-cycle reference model.
// The model tracks owner/grant/register from the arbitration rules using plain integers.
// Inputs are driven 1 time unit after rising edges; outputs are compared at the same offset.
module tb_shared_reg_arbiter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MH = 4;

   logic           clk   = 1'b0;
   logic           rst   = 1'b0;
   logic [N-1:0]   req   = '0;
   logic [N-1:0]   lock  = '0;
   logic [N*W-1:0] wdata = '0;
   logic [N-1:0]   gnt;
   logic [2:0]     owner;
   logic           busy;
   logic [W-1:0]   q;

   int n_tests = 0;
   int n_fail  = 0;

   shared_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .wdata(wdata),
      .gnt(gnt), .owner(owner), .busy(busy), .q(q)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic bit req_bit(input int c);
      logic [N-1:0] t;
      t = req >> c;
      return t[0];
   endfunction

   function automatic bit lock_bit(input int c);
      logic [N-1:0] t;
      t = lock >> c;
      return t[0];
   endfunction

   function automatic logic [W-1:0] data_of(input int c);
      logic [N*W-1:0] t;
      t = wdata >> (c * W);
      return t[W-1:0];
   endfunction

   // Reference model: m_idx = -1 when nobody holds the register.
   int         m_idx   = -1;
   int         m_owner = 0;
   int         m_ptr   = 0;
   int         m_cnt   = 0;
   logic [W-1:0] m_q   = '0;
   bit         m_rel;
   int         m_cand;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_idx = -1; m_owner = 0; m_ptr = 0; m_cnt = 0; m_q = '0;
      end else if (m_idx < 0) begin
         for (int off = 0; off < N; off++) begin
            m_cand = (m_ptr + off) % N;
            if (m_idx < 0 && req_bit(m_cand)) begin
               m_idx   = m_cand;
               m_owner = m_cand;
               m_cnt   = 0;
            end
         end
      end else begin
         m_rel = 1'b0;
         if (req_bit(m_idx)) begin
            m_q   = data_of(m_idx);
            m_cnt = m_cnt + 1;
            if (m_cnt == MH || !lock_bit(m_idx)) m_rel = 1'b1;
         end else begin
            m_rel = 1'b1;
         end
         if (m_rel) begin
            m_ptr = (m_idx + 1) % N;
            m_idx = -1;
         end
      end
   end

   // Per-cycle comparison of the DUT against the model.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         check("cmp_gnt",   32'(gnt),   (m_idx < 0) ? 32'h0 : (32'h1 << m_idx));
         check("cmp_busy",  32'(busy),  (m_idx < 0) ? 32'h0 : 32'h1);
         check("cmp_owner", 32'(owner), 32'(m_owner));
         check("cmp_q",     32'(q),     32'(m_q));
      end
   end

   initial begin
      // Reset state
      #12;
      check("rst_q", 32'(q), 32'h0);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_owner", 32'(owner), 32'h0);
      step;
      rst = 1'b1;

      // Asynchronous reset while q=A5 and gnt=0100
      req = 4'b0100; lock = 4'b0100; wdata[2*W +: W] = 8'hA5;
      step;
      check("a_gnt", 32'(gnt), 32'h4);
      step;
      check("a_q", 32'(q), 32'hA5);
      check("a_gnt_hold", 32'(gnt), 32'h4);
      #2 rst = 1'b0;
      #1;
      check("a_rst_q", 32'(q), 32'h0);
      check("a_rst_gnt", 32'(gnt), 32'h0);
      check("a_rst_busy", 32'(busy), 32'h0);
      check("a_rst_owner", 32'(owner), 32'h0);
      #1;
      req = '0; lock = '0; rst = 1'b1;

      // Round-robin with all requesting, unlocked
      req = 4'b1111;
      for (int i = 0; i < N; i++) wdata[i*W +: W] = W'(16 + i);
      for (int g = 0; g < 5; g++) begin
         step;
         check("rr_gnt", 32'(gnt), 32'h1 << (g % N));
         step;
         check("rr_q", 32'(q), 32'(16 + (g % N)));
         check("rr_busy_drop", 32'(busy), 32'h0);
      end
      req = '0;

      // Single unlocked write
      req = 4'b0001; wdata[0 +: W] = 8'h3C; lock = '0;
      step;
      check("b_gnt", 32'(gnt), 32'h1);
      check("b_busy", 32'(busy), 32'h1);
      step;
      check("b_q", 32'(q), 32'h3C);
      check("b_gnt_off", 32'(gnt), 32'h0);
      check("b_busy_off", 32'(busy), 32'h0);
      req = '0;
      step;
      check("b_q_hold", 32'(q), 32'h3C);

      // Locked burst hits the hold limit
      req = 4'b0010; lock = 4'b0010; wdata[1*W +: W] = 8'd1;
      step;
      check("d_gnt", 32'(gnt), 32'h2);
      for (int n = 1; n <= 4; n++) begin
         wdata[1*W +: W] = W'(n);
         step;
         check("d_q", 32'(q), 32'(n));
         check("d_gnt_burst", 32'(gnt), (n < 4) ? 32'h2 : 32'h0);
      end
      wdata[1*W +: W] = 8'd5;
      step;
      check("d_regrant", 32'(gnt), 32'h2);
      check("d_q_idle", 32'(q), 32'h4);
      step;
      check("d_q5", 32'(q), 32'h5);
      req = '0;
      step;
      check("d_drop_gnt", 32'(gnt), 32'h0);
      check("d_drop_q", 32'(q), 32'h5);

      // Early release with a pending request that wraps around
      req = 4'b0100; lock = 4'b0100; wdata[2*W +: W] = 8'h21;
      step;
      check("e_gnt", 32'(gnt), 32'h4);
      req = 4'b0101;
      step;
      check("e_q1", 32'(q), 32'h21);
      wdata[2*W +: W] = 8'h22;
      step;
      check("e_q2", 32'(q), 32'h22);
      check("e_gnt_held", 32'(gnt), 32'h4);
      req = 4'b0001; wdata[2*W +: W] = 8'h99;
      step;
      check("e_nowrite", 32'(q), 32'h22);
      check("e_rel", 32'(gnt), 32'h0);
      step;
      check("e_wrap_gnt", 32'(gnt), 32'h1);
      check("e_wrap_owner", 32'(owner), 32'h0);
      wdata[0 +: W] = 8'h40;
      step;
      check("e_q0", 32'(q), 32'h40);
      req = '0; lock = '0;

      // Reset in the middle of a locked burst by requester 3
      req = 4'b1000; lock = 4'b1000; wdata[3*W +: W] = 8'h77;
      step;
      check("f_owner", 32'(owner), 32'h3);
      step;
      check("f_q", 32'(q), 32'h77);
      #2 rst = 1'b0;
      #1;
      check("f_rst_q", 32'(q), 32'h0);
      check("f_rst_gnt", 32'(gnt), 32'h0);
      check("f_rst_busy", 32'(busy), 32'h0);
      check("f_rst_owner", 32'(owner), 32'h0);
      req = 4'b1001; lock = '0; wdata[0 +: W] = 8'h5A;
      #2 rst = 1'b1;
      step;
      check("f_first_gnt", 32'(gnt), 32'h1);
      step;
      check("f_first_q", 32'(q), 32'h5A);
      req = '0;
      step;
      step;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
